fft16_output_unloader: RTL and testbench

Output-side counterpart of the FFT input loader. Captures one frame of 16 complex stage-2 results from the FFT core's flattened output buses on a `start` pulse. Streams them out one bin per beat over a valid/ready interface, with a bin index, last-beat flag and completion pulse. Sits between the 16-point radix-4 FFT datapath and downstream consumers such as a magnitude unit, DMA or UART bridge.

---
 rtl/fft16_output_unloader.sv | 132 +++++++++++++
 tb/tb_fft16_output_unloader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_output_unloader.sv
// fft16_output_unloader
// Captures one 16-bin frame from the FFT core's flattened output buses on a
// start pulse, then streams it out one bin per beat over valid/ready, with a
// bin index, last-beat flag, completion pulse and sticky overrun flag.
//
// Build option FFT16_DIGIT_REVERSE_EN:
//   defined   - natural bin order: out_addr = cnt, data from entry digitrev(cnt)
//   undefined - raw datapath order: data from entry cnt, out_addr = digitrev(cnt)
module fft16_output_unloader #(
    parameter int N    = 16,
    parameter int OUTW = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*OUTW-1:0]      yr_flat,
    input  logic [N*OUTW-1:0]      yi_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_addr,
    output logic signed [OUTW-1:0] out_re,
    output logic signed [OUTW-1:0] out_im,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      cnt;
    logic [3:0]      cnt_rev;
    logic [3:0]      sel;
    logic            capture;
    logic            final_beat;
    logic            accept;
    logic            streaming;
    logic [OUTW-1:0] snap_re [N];
    logic [OUTW-1:0] snap_im [N];

    // Radix-4 digit reversal swaps the two base-4 digits of the 4-bit index.
    assign cnt_rev   = {cnt[1:0], cnt[3:2]};
    assign streaming = (state == STREAM);
    assign accept    = streaming && out_ready;

`ifdef FFT16_DIGIT_REVERSE_EN
    assign sel      = cnt_rev;
    assign out_addr = cnt;
`else
    assign sel      = cnt;
    assign out_addr = cnt_rev;
`endif

    // Outputs decode from registered state only, so out_ready never reaches out_valid.
    assign out_valid = streaming;
    assign busy      = streaming;
    assign out_last  = streaming && (cnt == 4'd15);
    assign out_re    = streaming ? snap_re[sel] : '0;
    assign out_im    = streaming ? snap_im[sel] : '0;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: capture in IDLE on start, leave STREAM after beat 15 is taken.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        final_beat = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (out_ready && (cnt == 4'd15)) begin
                    final_beat = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter wraps 15->0 on the final beat so IDLE always rests at cnt=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= final_beat;
            if (capture) begin
                cnt     <= 4'd0;
                overrun <= 1'b0;
            end else if (accept) begin
                cnt <= cnt + 4'd1;
            end
            if (streaming && start) begin
                overrun <= 1'b1;
            end
        end
    end

    // Snapshot registers load only on an accepted start; later starts never overwrite them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int m = 0; m < N; m++) begin
                snap_re[m] <= '0;
                snap_im[m] <= '0;
            end
        end else if (capture) begin
            for (int m = 0; m < N; m++) begin
                snap_re[m] <= yr_flat[m*OUTW +: OUTW];
                snap_im[m] <= yi_flat[m*OUTW +: OUTW];
            end
        end
    end

endmodule

// File: tb/tb_fft16_output_unloader.sv
// Testbench for fft16_output_unloader: scoreboard of expected beats filled
// when a start is issued, drained by an independent negedge monitor.
`timescale 1ns/1ps
module tb_fft16_output_unloader;

    localparam int N    = 16;
    localparam int OUTW = 48;

    logic                   clk       = 1'b0;
    logic                   rst       = 1'b0;
    logic                   start     = 1'b0;
    logic                   out_ready = 1'b0;
    logic [N*OUTW-1:0]      yr_flat   = '0;
    logic [N*OUTW-1:0]      yi_flat   = '0;
    logic                   out_valid;
    logic [3:0]             out_addr;
    logic signed [OUTW-1:0] out_re;
    logic signed [OUTW-1:0] out_im;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    typedef struct packed {
        logic [3:0]      addr;
        logic [OUTW-1:0] re;
        logic [OUTW-1:0] im;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    checks      = 0;
    int    errors      = 0;
    logic  exp_overrun = 1'b0;
    logic  exp_done    = 1'b0;

    fft16_output_unloader #(.N(N), .OUTW(OUTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .yr_flat   (yr_flat),
        .yi_flat   (yi_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [OUTW-1:0] actual,
                               input logic [OUTW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] digitRev(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction

    // Frame contents: kind 0 is re=m+100, im=-m; others exercise wide/negative words.
    function automatic logic [OUTW-1:0] wordRe(input int kind, input int m);
        case (kind)
            0:       return OUTW'(m + 100);
            1:       return OUTW'(m * 3 + 7);
            default: return 48'h7FFF_0000_0000 - OUTW'(m);
        endcase
    endfunction

    function automatic logic [OUTW-1:0] wordIm(input int kind, input int m);
        case (kind)
            0:       return -OUTW'(m);
            1:       return OUTW'(m * 1000) - OUTW'(5);
            default: return 48'h8000_0000_0000 + OUTW'(m);
        endcase
    endfunction

    task automatic pushFrame(input int kind);
        beat_t       b;
        logic [3:0]  k4;
        logic [3:0]  m4;
        for (int k = 0; k < N; k++) begin
            k4 = 4'(k);
`ifdef FFT16_DIGIT_REVERSE_EN
            m4     = digitRev(k4);
            b.addr = k4;
`else
            m4     = k4;
            b.addr = digitRev(k4);
`endif
            b.re   = wordRe(kind, int'(m4));
            b.im   = wordIm(kind, int'(m4));
            b.last = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    // Present frame data with a one-cycle start; called and returns at posedge+1.
    task automatic applyStimulus(input int kind, input logic expect_accept);
        for (int m = 0; m < N; m++) begin
            yr_flat[m*OUTW +: OUTW] = wordRe(kind, m);
            yi_flat[m*OUTW +: OUTW] = wordIm(kind, m);
        end
        start = 1'b1;
        @(posedge clk);
        if (expect_accept) begin
            pushFrame(kind);
            exp_overrun = 1'b0;
        end else begin
            exp_overrun = 1'b1;
        end
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int max_cycles);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        if (i == max_cycles) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_done actual=timeout expected=done");
        end
    endtask

    // Monitor: checks control outputs every cycle and pops the scoreboard on each accepted beat.
    initial begin
        beat_t b;
        beat_t hold_beat;
        logic  hold_pending;
        hold_pending = 1'b0;
        hold_beat    = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("rst_valid", OUTW'(out_valid), '0);
                checkOutput("rst_addr", OUTW'(out_addr), '0);
                checkOutput("rst_re", out_re, '0);
                checkOutput("rst_im", out_im, '0);
                checkOutput("rst_flags", OUTW'({out_last, busy, done, overrun}), '0);
                exp_done     = 1'b0;
                hold_pending = 1'b0;
            end else begin
                checkOutput("done", OUTW'(done), OUTW'(exp_done));
                checkOutput("busy", OUTW'(busy), OUTW'(exp_q.size() != 0));
                checkOutput("valid", OUTW'(out_valid), OUTW'(exp_q.size() != 0));
                checkOutput("overrun", OUTW'(overrun), OUTW'(exp_overrun));
                if (hold_pending && out_valid) begin
                    checkOutput("hold_addr", OUTW'(out_addr), OUTW'(hold_beat.addr));
                    checkOutput("hold_re", out_re, hold_beat.re);
                    checkOutput("hold_im", out_im, hold_beat.im);
                    checkOutput("hold_last", OUTW'(out_last), OUTW'(hold_beat.last));
                end
                exp_done = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL beat actual=addr%0d expected=none", out_addr);
                    end else begin
                        b = exp_q.pop_front();
                        checkOutput("beat_addr", OUTW'(out_addr), OUTW'(b.addr));
                        checkOutput("beat_re", out_re, b.re);
                        checkOutput("beat_im", out_im, b.im);
                        checkOutput("beat_last", OUTW'(out_last), OUTW'(b.last));
                        exp_done = b.last;
                    end
                end
                hold_pending   = out_valid && !out_ready;
                hold_beat.addr = out_addr;
                hold_beat.re   = out_re;
                hold_beat.im   = out_im;
                hold_beat.last = out_last;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [3:0] pat;
        int         i;
        pat = 4'b1001;

        // Reset held low with random inputs and start asserted.
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int w = 0; w < N * OUTW / 32; w++) begin
                yr_flat[w*32 +: 32] = $urandom();
                yi_flat[w*32 +: 32] = $urandom();
            end
            start     = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Frame A with directed check of beat 1.
        applyStimulus(0, 1'b1);
        @(posedge clk);
        #1;
`ifdef FFT16_DIGIT_REVERSE_EN
        checkOutput("beat1_addr", OUTW'(out_addr), OUTW'(1));
        checkOutput("beat1_re", out_re, OUTW'(104));
        checkOutput("beat1_im", out_im, 48'hFFFF_FFFF_FFFC);
`else
        checkOutput("beat1_addr", OUTW'(out_addr), OUTW'(4));
        checkOutput("beat1_re", out_re, OUTW'(101));
        checkOutput("beat1_im", out_im, 48'hFFFF_FFFF_FFFF);
`endif
        waitDone(30);

        // Back-to-back: start in the done cycle.
        applyStimulus(2, 1'b1);
        waitDone(30);
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Backpressure with ready pattern 1,0,0,1.
        applyStimulus(1, 1'b1);
        for (i = 0; i < 100 && exp_q.size() != 0; i++) begin
            out_ready = pat[i % 4];
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL backpressure_drain actual=%0d expected=0", exp_q.size());
        end
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Overrun at beat 5, then again on the final beat of the next frame.
        applyStimulus(0, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(1, 1'b0);
        waitDone(30);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(2, 1'b1);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(1, 1'b0);
        waitDone(30);
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Reset mid-frame at beat 8.
        applyStimulus(0, 1'b1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        exp_overrun = 1'b0;
        #1;
        checkOutput("midrst_valid", OUTW'(out_valid), '0);
        checkOutput("midrst_busy", OUTW'(busy), '0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // Recovery frame after reset.
        applyStimulus(1, 1'b1);
        waitDone(30);
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
